// File: rtl/demux8_rr_scheduler.sv
// 1x8 demux sequencer: round-robin over enabled channels, one registered output stage.
// Define DEMUX_ADDR_MODE_EN to add addressed selection (addr_mode/in_addr) with drop.
module demux8_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int PTR_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       ch_en,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic             busy
`ifdef DEMUX_ADDR_MODE_EN
  ,
  input  logic             addr_mode,
  input  logic [2:0]       in_addr,
  output logic             drop
`endif
);

  localparam logic [2:0] PtrRst = 3'(PTR_RST);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic       drain;
  logic       can_take;
  logic       accept;
  logic       load;
  logic       adv_ptr;
  logic [2:0] pick;
  logic       rr_hit;
  logic [2:0] rr_idx;

  // First enabled channel at or after ptr, wrapping mod 8.
  always_comb begin
    logic [2:0] cand;
    rr_hit = 1'b0;
    rr_idx = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!rr_hit && ch_en[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign drain    = (state_q == HOLD) && out_ready[sel_q];
  assign can_take = (state_q == IDLE) || drain;
  assign accept   = in_valid && in_ready;

`ifdef DEMUX_ADDR_MODE_EN
  logic drop_q, drop_d;

  assign in_ready = can_take && (addr_mode || (|ch_en));
  assign pick     = addr_mode ? in_addr : rr_idx;
  assign load     = accept && (!addr_mode || ch_en[in_addr]);
  assign adv_ptr  = accept && !addr_mode;
  assign drop_d   = accept && addr_mode && !ch_en[in_addr];
  assign drop     = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= drop_d;
  end
`else
  assign in_ready = can_take && (|ch_en);
  assign pick     = rr_idx;
  assign load     = accept;
  assign adv_ptr  = accept;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (adv_ptr) ptr_d = rr_idx + 3'd1;
    if (load) begin
      sel_d  = pick;
      data_d = in_data;
    end
    unique case (state_q)
      IDLE: if (load) state_d = HOLD;
      HOLD: begin
        if (load)       state_d = HOLD;
        else if (drain) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PtrRst;
      sel_q   <= 3'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign busy      = (state_q == HOLD);
  assign out_valid = busy ? (8'b1 << sel_q) : 8'b0;
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// Bench for demux8_rr_scheduler: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux8_rr_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [7:0]   ch_en;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   sel;
  logic         busy;
`ifdef DEMUX_ADDR_MODE_EN
  logic         addr_mode;
  logic [2:0]   in_addr;
  logic         drop;
`endif

  always #5 clk = ~clk;

  demux8_rr_scheduler #(
    .WIDTH  (W),
    .PTR_RST(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ch_en    (ch_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sel      (sel),
    .busy     (busy)
`ifdef DEMUX_ADDR_MODE_EN
    ,
    .addr_mode(addr_mode),
    .in_addr  (in_addr),
    .drop     (drop)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: held word (if any), its channel and data, round-robin pointer.
  bit m_hold;
  int m_sel;
  int m_data;
  int m_ptr;
  bit m_drop;
  int log_ch[$];
  int log_d[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_addr();
`ifdef DEMUX_ADDR_MODE_EN
    return addr_mode;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready();
    bit room;
    room = !m_hold || out_ready[m_sel];
    return room && (m_addr() || ch_en != 8'h00);
  endfunction

  task automatic model_reset();
    m_hold = 0;
    m_sel  = 0;
    m_data = 0;
    m_ptr  = 0;
    m_drop = 0;
  endtask

  task automatic compare();
    chk("in_ready", in_ready, exp_ready());
    chk("out_valid", out_valid, m_hold ? (32'd1 << m_sel) : 32'd0);
    chk("out_data", out_data, m_data);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_hold);
`ifdef DEMUX_ADDR_MODE_EN
    chk("drop", drop, m_drop);
`endif
  endtask

  task automatic model_tick();
    bit acc, dlv, ld;
    int tgt;
    acc = in_valid && exp_ready();
    dlv = m_hold && out_ready[m_sel];
    ld  = 0;
    tgt = 0;
    if (dlv) begin
      log_ch.push_back(m_sel);
      log_d.push_back(m_data);
    end
    m_drop = 0;
    if (acc) begin
      if (m_addr()) begin
`ifdef DEMUX_ADDR_MODE_EN
        tgt = int'(in_addr);
`endif
        if (ch_en[tgt]) ld = 1;
        else m_drop = 1;
      end else begin
        for (int k = 0; k < 8; k++) begin
          int i;
          i = (m_ptr + k) % 8;
          if (!ld && ch_en[i]) begin
            ld  = 1;
            tgt = i;
          end
        end
        m_ptr = (tgt + 1) % 8;
      end
    end
    if (ld) begin
      m_hold = 1;
      m_sel  = tgt;
      m_data = int'(in_data);
    end else if (dlv) begin
      m_hold = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_d.delete();
  endtask

  task automatic chk_log(string nm, int idx, int ch, int d);
    if (idx >= log_ch.size()) begin
      chk({nm, "_missing"}, 32'(log_ch.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_ch"}, 32'(log_ch[idx]), 32'(ch));
      chk({nm, "_data"}, 32'(log_d[idx]), 32'(d));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_en     = 8'h00;
    out_ready = 8'h00;
`ifdef DEMUX_ADDR_MODE_EN
    addr_mode = 1'b0;
    in_addr   = 3'd0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_sel", sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // All channels enabled: strict 0..7 order.
    clear_log();
    ch_en     = 8'hFF;
    out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + k);
      #1;
      chk("t1_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("t1_count", 32'(log_ch.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk_log("t1", k, k, 8'h10 + k);

    // Two enabled channels alternate at full rate.
    clear_log();
    ch_en = 8'h24;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + k);
      #1;
      chk("t2_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk_log("t2", 0, 2, 8'h40);
    chk_log("t2", 1, 5, 8'h41);
    chk_log("t2", 2, 2, 8'h42);
    chk_log("t2", 3, 5, 8'h43);

    // Channel 3 stalls: word held, input blocked.
    clear_log();
    ch_en     = 8'h08;
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step();
    in_data = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_valid", out_valid, 8'h08);
      chk("t3_data", out_data, 8'hA5);
      chk("t3_ready", in_ready, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    repeat (2) step();
    chk("t3_count", 32'(log_ch.size()), 32'd1);
    chk_log("t3", 0, 3, 8'hA5);

    // No channel enabled: nothing accepted until ch0 enabled.
    clear_log();
    ch_en    = 8'h00;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_ready", in_ready, 1'b0);
      chk("t4_valid", out_valid, 8'h00);
      step();
    end
    ch_en = 8'h01;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk_log("t4", 0, 0, 8'h77);

    // Held word survives its channel being disabled.
    clear_log();
    ch_en     = 8'h10;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    step();
    in_valid = 1'b0;
    ch_en    = 8'h01;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_valid", out_valid, 8'h10);
      step();
    end
    out_ready = 8'hFF;
    repeat (2) step();
    chk_log("t5", 0, 4, 8'h3C);

    // Asynchronous reset while holding.
    ch_en     = 8'hFF;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    step();
    in_valid = 1'b0;
    #1;
    chk("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 8'h00);
    chk("t6_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 8'hFF;
    step();

`ifdef DEMUX_ADDR_MODE_EN
    // Addressed word to a disabled channel is dropped.
    addr_mode = 1'b1;
    in_addr   = 3'd6;
    ch_en     = 8'hBF;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    step();
    in_valid = 1'b0;
    #1;
    chk("t7_drop", drop, 1'b1);
    chk("t7_valid", out_valid, 8'h00);
    step();
    #1;
    chk("t7_drop_end", drop, 1'b0);
    addr_mode = 1'b0;
    step();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: ch_en = 8'h00;
          1: ch_en = 8'(1 << $urandom_range(7));
          default: ch_en = 8'($urandom);
        endcase
      end
`ifdef DEMUX_ADDR_MODE_EN
      addr_mode = ($urandom_range(3) == 0);
      in_addr   = 3'($urandom);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
